// File: rtl/dbg_pkg.sv
// dbg_pkg: FSM state encoding, local register offsets and default error data for dbg_cpu_mux
package dbg_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic [1:0] LOC_STATUS = 2'd0;
  localparam logic [1:0] LOC_BPMASK = 2'd1;
  localparam logic [1:0] LOC_STALL = 2'd2;
  localparam logic [1:0] LOC_SEL = 2'd3;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/dbg_cpu_mux_if.sv
// dbg_cpu_mux_if: upstream debug bus plus the fanned-out per-core debug ports
interface dbg_cpu_mux_if #(
  parameter int NB_CORES = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic stb;
  logic we;
  logic ack;
  logic stall;
  logic bp;
  logic [NB_CORES*ADDR_WIDTH-1:0] cpu_addr;
  logic [NB_CORES*DATA_WIDTH-1:0] cpu_wdata;
  logic [NB_CORES*DATA_WIDTH-1:0] cpu_rdata;
  logic [NB_CORES-1:0] cpu_stb;
  logic [NB_CORES-1:0] cpu_we;
  logic [NB_CORES-1:0] cpu_ack;
  logic [NB_CORES-1:0] cpu_bp;
  logic [NB_CORES-1:0] cpu_stall;
  modport slave (
    input addr, wdata, stb, we, stall, cpu_rdata, cpu_ack, cpu_bp,
    output rdata, ack, bp, cpu_addr, cpu_wdata, cpu_stb, cpu_we, cpu_stall
  );
  modport master (
    output addr, wdata, stb, we, stall, cpu_rdata, cpu_ack, cpu_bp,
    input rdata, ack, bp, cpu_addr, cpu_wdata, cpu_stb, cpu_we, cpu_stall
  );
endinterface

// File: rtl/dbg_cpu_mux.sv
// dbg_cpu_mux: fans one debug CPU bus out to NB_CORES cores with local control regs, ack timeout and group halt
module dbg_cpu_mux
  import dbg_pkg::*;
#(
  parameter int NB_CORES = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 1023,
  parameter int GROUP_HALT = 1,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_DATA_DEF)
) (
  input logic clk,
  input logic rst,
  dbg_cpu_mux_if.slave bus
);
  localparam int SW = NB_CORES > 1 ? $clog2(NB_CORES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  state_t state, next;
  logic gap;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data, rdata, loc_rd, core_rd;
  logic a_we, err, is_local, take, wr, hit_ack, expired, grp;
  logic [SW-1:0] sel, a_sel;
  logic [NB_CORES-1:0] stall_reg, bp_sticky, bp_mask, bp_q, bp_hit, clr;
  logic [NB_CORES-1:0] stb_v, we_v;
  logic [NB_CORES*ADDR_WIDTH-1:0] addr_v;
  logic [NB_CORES*DATA_WIDTH-1:0] data_v;
  logic [TW-1:0] timer;
  logic [1:0] wa;
  assign wa = bus.addr[1:0];
  assign is_local = &bus.addr[ADDR_WIDTH-1:2];
  assign take = state == IDLE && !gap && bus.stb;
  assign wr = take && is_local && bus.we;
  assign hit_ack = bus.cpu_ack[a_sel];
  assign expired = timer == TLAST;
  assign core_rd = bus.cpu_rdata[a_sel*DATA_WIDTH +: DATA_WIDTH];
  assign bp_hit = bus.cpu_bp & ~bp_mask;
  assign grp = GROUP_HALT != 0 && |(bp_hit & ~bp_q);
  assign clr = wr && wa == LOC_STATUS ? bus.wdata[NB_CORES-1:0] : '0;
  always_comb begin
    next = state == RESP ? IDLE :
           state == REQ ? (hit_ack || expired ? RESP : REQ) :
           take ? (is_local ? RESP : REQ) : IDLE;
    loc_rd = wa == LOC_SEL ? DATA_WIDTH'(sel) :
             wa == LOC_STALL ? DATA_WIDTH'(stall_reg) :
             wa == LOC_BPMASK ? DATA_WIDTH'(bp_mask) : DATA_WIDTH'({err, bp_sticky});
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gap <= 1'b0;
      a_addr <= '0;
      a_data <= '0;
      a_we <= 1'b0;
      a_sel <= '0;
      sel <= '0;
      rdata <= '0;
      err <= 1'b0;
      timer <= '0;
      stall_reg <= '0;
      bp_sticky <= '0;
      bp_mask <= '0;
      bp_q <= '0;
    end else begin
      state <= next;
      gap <= state == RESP;
      bp_q <= bp_hit;
      bp_sticky <= (bp_sticky & ~clr) | bp_hit;
      stall_reg <= grp ? '1 : wr && wa == LOC_STALL ? bus.wdata[NB_CORES-1:0] : stall_reg;
      if (take) begin
        a_addr <= bus.addr;
        a_data <= bus.wdata;
        a_we <= bus.we;
        a_sel <= sel;
        timer <= '0;
      end else if (state == REQ) begin
        timer <= timer == TMAX ? timer : timer + 1'b1;
      end
      if (take && is_local && !bus.we) rdata <= loc_rd;
      if (state == REQ && hit_ack) begin
        rdata <= core_rd;
      end else if (state == REQ && expired) begin
        rdata <= ERR_DATA;
        err <= 1'b1;
      end
      if (wr && wa == LOC_SEL && bus.wdata < DATA_WIDTH'(NB_CORES)) sel <= SW'(bus.wdata);
      if (wr && wa == LOC_BPMASK) bp_mask <= bus.wdata[NB_CORES-1:0];
      if (wr && wa == LOC_STATUS && bus.wdata[NB_CORES]) err <= 1'b0;
    end
  end
  for (genvar i = 0; i < NB_CORES; i++) begin : g_core
    assign stb_v[i] = state == REQ && a_sel == SW'(i);
    assign we_v[i] = stb_v[i] && a_we;
    assign addr_v[i*ADDR_WIDTH +: ADDR_WIDTH] = stb_v[i] ? a_addr : '0;
    assign data_v[i*DATA_WIDTH +: DATA_WIDTH] = stb_v[i] ? a_data : '0;
  end
  assign bus.cpu_stb = stb_v;
  assign bus.cpu_we = we_v;
  assign bus.cpu_addr = addr_v;
  assign bus.cpu_wdata = data_v;
  assign bus.ack = state == RESP;
  assign bus.rdata = rdata;
  assign bus.bp = |bp_sticky;
  assign bus.cpu_stall = stall_reg | {NB_CORES{bus.stall}};
endmodule

// File: tb/tb_dbg_cpu_mux.sv
// tb_dbg_cpu_mux: vector table, directed corner sequences and randomized traffic against a spec-level model
module tb_dbg_cpu_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  dbg_cpu_mux_if #(.NB_CORES(4), .ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();
  dbg_cpu_mux #(
    .NB_CORES(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT(15),
    .GROUP_HALT(1), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [15:0] a;
    logic w;
    logic [31:0] d;
    int lat;
    logic [31:0] cd;
    int core;
    logic [31:0] exp_d;
    int exp_n;
  } vec_t;
  vec_t tv[17];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // One upstream transaction; the bench plays the cores, acking the expected core on its lat-th strobe cycle.
  task automatic access(input logic [15:0] a, input logic w, input logic [31:0] d, input int lat,
                        input logic [31:0] cd, input int core, input bit noise,
                        output logic [31:0] rd, output int n, output int bad);
    int sc;
    bit done;
    logic [3:0] s;
    sc = 0; bad = 0; n = -1; rd = '0; done = 0;
    bus.addr = a; bus.we = w; bus.wdata = d; bus.stb = 1'b1;
    for (int k = 2; k <= 60 && !done; k++) begin
      tick();
      s = bus.cpu_stb;
      if (core < 0) begin
        if (s != 4'b0) bad++;
      end else if (s != 4'b0) begin
        if (s != 4'(1 << core)) bad++;
        else begin
          sc++;
          if (bus.cpu_addr[core*16 +: 16] != a || bus.cpu_wdata[core*32 +: 32] != d || bus.cpu_we[core] != w) bad++;
        end
      end
      bus.cpu_ack = noise ? 4'($urandom) : 4'b0;
      for (int c = 0; c < 4; c++) bus.cpu_rdata[c*32 +: 32] = $urandom;
      if (core >= 0) begin
        bus.cpu_ack[core] = s[core] && sc == lat;
        if (s[core] && sc == lat) bus.cpu_rdata[core*32 +: 32] = cd;
      end
      if (bus.ack) begin
        rd = bus.rdata; n = k; done = 1;
      end
    end
    tick();
    if (bus.ack) bad++;
    bus.stb = 1'b0; bus.cpu_ack = '0;
    tick();
    if (bus.ack || bus.cpu_stb != 4'b0) bad++;
  endtask
  logic [31:0] rd, d, cd, exp_d;
  int n, bad, lat, lv, exp_n, acks;
  logic [15:0] a;
  logic w, st, merr;
  logic [1:0] off, msel;
  logic [3:0] mstall, mmask;
  initial begin
    tv[0]  = '{16'hFFFF, 1, 32'd7, 0, 0, -1, 0, 2};
    tv[1]  = '{16'hFFFF, 0, 0, 0, 0, -1, 32'd0, 2};
    tv[2]  = '{16'hFFFF, 1, 32'd2, 0, 0, -1, 0, 2};
    tv[3]  = '{16'hFFFF, 0, 0, 0, 0, -1, 32'd2, 2};
    tv[4]  = '{16'h0010, 0, 0, 3, 32'h1234_5678, 2, 32'h1234_5678, 5};
    tv[5]  = '{16'h0011, 1, 32'h0000_AABB, 1, 0, 2, 0, 3};
    tv[6]  = '{16'hFFFF, 1, 32'd1, 0, 0, -1, 0, 2};
    tv[7]  = '{16'h0020, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 17};
    tv[8]  = '{16'hFFFC, 0, 0, 0, 0, -1, 32'h10, 2};
    tv[9]  = '{16'hFFFC, 1, 32'h10, 0, 0, -1, 0, 2};
    tv[10] = '{16'hFFFC, 0, 0, 0, 0, -1, 32'h0, 2};
    tv[11] = '{16'h0030, 0, 0, 15, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 17};
    tv[12] = '{16'hFFFC, 0, 0, 0, 0, -1, 32'h0, 2};
    tv[13] = '{16'hFFFE, 1, 32'h5, 0, 0, -1, 0, 2};
    tv[14] = '{16'hFFFE, 0, 0, 0, 0, -1, 32'h5, 2};
    tv[15] = '{16'hFFFD, 1, 32'h3, 0, 0, -1, 0, 2};
    tv[16] = '{16'hFFFD, 0, 0, 0, 0, -1, 32'h3, 2};
    bus.addr = '0; bus.wdata = '0; bus.stb = 0; bus.we = 0; bus.stall = 0;
    bus.cpu_rdata = '0; bus.cpu_ack = '0; bus.cpu_bp = '0;
    repeat (3) tick();
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_stb", 32'(bus.cpu_stb), 0);
    chk("rst_stall", 32'(bus.cpu_stall), 0);
    chk("rst_bp", 32'(bus.bp), 0);
    chk("rst_rdata", bus.rdata, 0);
    rst = 0;
    for (int i = 0; i < 17; i++) begin
      access(tv[i].a, tv[i].w, tv[i].d, tv[i].lat, tv[i].cd, tv[i].core, 0, rd, n, bad);
      if (!tv[i].w) chk($sformatf("vec%0d_data", i), rd, tv[i].exp_d);
      chk($sformatf("vec%0d_lat", i), 32'(n), 32'(tv[i].exp_n));
      chk($sformatf("vec%0d_bus", i), 32'(bad), 0);
    end
    chk("vec_stall", 32'(bus.cpu_stall), 32'h5);
    bus.cpu_bp = 4'b1000;
    tick();
    bus.cpu_bp = 4'b0;
    chk("ghalt_stall", 32'(bus.cpu_stall), 32'hF);
    chk("ghalt_bp", 32'(bus.bp), 1);
    access(16'hFFFC, 0, 0, 0, 0, -1, 0, rd, n, bad);
    chk("ghalt_status", rd, 32'h8);
    access(16'hFFFE, 1, 0, 0, 0, -1, 0, rd, n, bad);
    access(16'hFFFC, 1, 32'h8, 0, 0, -1, 0, rd, n, bad);
    chk("bpclr_stall", 32'(bus.cpu_stall), 0);
    chk("bpclr_bp", 32'(bus.bp), 0);
    access(16'hFFFD, 1, 32'hB, 0, 0, -1, 0, rd, n, bad);
    bus.cpu_bp = 4'b1001;
    tick();
    bus.cpu_bp = 4'b0;
    tick();
    chk("masked_stall", 32'(bus.cpu_stall), 0);
    chk("masked_bp", 32'(bus.bp), 0);
    bus.stall = 1;
    #1;
    chk("up_stall", 32'(bus.cpu_stall), 32'hF);
    bus.stall = 0;
    bus.cpu_bp = 4'b0100;
    access(16'hFFFC, 1, 32'h4, 0, 0, -1, 0, rd, n, bad);
    access(16'hFFFC, 0, 0, 0, 0, -1, 0, rd, n, bad);
    chk("set_wins", rd, 32'h4);
    bus.cpu_bp = 4'b0;
    access(16'hFFFC, 1, 32'h4, 0, 0, -1, 0, rd, n, bad);
    access(16'hFFFC, 0, 0, 0, 0, -1, 0, rd, n, bad);
    chk("clr_after", rd, 32'h0);
    access(16'hFFFF, 1, 32'd3, 0, 0, -1, 0, rd, n, bad);
    bus.addr = 16'h0040; bus.we = 0; bus.stb = 1;
    repeat (3) tick();
    chk("midrst_pre_stb", 32'(bus.cpu_stb), 32'h8);
    rst = 1; bus.stb = 0;
    tick();
    chk("midrst_stb", 32'(bus.cpu_stb), 0);
    chk("midrst_ack", 32'(bus.ack), 0);
    rst = 0;
    acks = 0;
    repeat (20) begin
      tick();
      if (bus.ack) acks++;
    end
    chk("midrst_no_ack", 32'(acks), 0);
    chk("midrst_stall", 32'(bus.cpu_stall), 0);
    chk("midrst_bp", 32'(bus.bp), 0);
    for (int r = 0; r < 4; r++) begin
      access(16'hFFFC + 16'(r), 0, 0, 0, 0, -1, 0, rd, n, bad);
      chk($sformatf("midrst_reg%0d", r), rd, 0);
    end
    msel = 0; mstall = 0; mmask = 0; merr = 0;
    for (int t = 0; t < 150; t++) begin
      st = 1'($urandom_range(0, 1));
      bus.stall = st;
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 5) begin
        off = 2'($urandom_range(0, 3));
        a = 16'hFFFC + 16'(off);
        d = off == 2'd3 ? 32'($urandom_range(0, 7)) : $urandom;
        exp_d = off == 2'd3 ? 32'(msel) : off == 2'd2 ? 32'(mstall) : off == 2'd1 ? 32'(mmask) : {27'd0, merr, 4'd0};
        exp_n = 2;
        access(a, w, d, 0, 0, -1, 1, rd, n, bad);
        if (w) begin
          if (off == 2'd3 && d < 4) msel = d[1:0];
          if (off == 2'd2) mstall = d[3:0];
          if (off == 2'd1) mmask = d[3:0];
          if (off == 2'd0 && d[4]) merr = 0;
        end
      end else begin
        a = 16'($urandom_range(0, 16'hFFFB));
        lv = $urandom_range(0, 7);
        lat = lv < 6 ? lv + 1 : lv == 6 ? 15 : 0;
        cd = $urandom;
        d = $urandom;
        exp_d = (lat >= 1 && lat <= 15) ? cd : 32'hDEAD_BEEF;
        exp_n = (lat >= 1 && lat <= 15) ? lat + 2 : 17;
        if (!(lat >= 1 && lat <= 15)) merr = 1;
        access(a, w, d, lat, cd, int'(msel), 1, rd, n, bad);
      end
      if (!w) chk($sformatf("rnd%0d_data", t), rd, exp_d);
      chk($sformatf("rnd%0d_lat", t), 32'(n), 32'(exp_n));
      chk($sformatf("rnd%0d_bus", t), 32'(bad), 0);
      chk($sformatf("rnd%0d_stall", t), 32'(bus.cpu_stall), 32'(mstall | {4{st}}));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
